// File: rtl/lane_bypass_regfile.sv
// ---------------------------------------------------------------------------
// lane_bypass_regfile
//
// Multi-lane register file with a result-tracking pipeline and operand
// bypass network for an N-issue in-order core. Every issued instruction
// occupies one entry per stage S1..SDEPTH. Its result is captured from the
// lane ALU (non-loads, while in S1) or from the lane data memory (loads,
// while in S2). It commits to the architectural registers when it leaves
// SDEPTH. Operands are served from the youngest in-flight producer. If that
// value is not yet available, or an older lane of the same bundle writes the
// source, the lane and every younger lane are held back.
//
// Issue handshake: decode offers iss_valid per lane and the block answers
// with iss_accept, a thermometer prefix starting at lane 0. A lane that
// offers but is not accepted must be offered again, unchanged, on the next
// cycle. The block keeps no record of lanes it did not accept.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   iss_valid      per lane: the lane holds an instruction this cycle
//   iss_wen        per lane: the instruction writes iss_rd
//   iss_load       per lane: the result comes from mem_data in S2
//   iss_rd         per lane destination register (RW bits per lane)
//   iss_rs_a/b     per lane source registers (RW bits per lane)
//   iss_accept     per lane: the lane issues this cycle
//   op_a/op_b      per lane bypassed source values (WIDTH bits per lane)
//   ex_data        per lane ALU result for that lane's S1 entry
//   mem_data       per lane load result for that lane's S2 entry
//   dbg_raddr      debug read address
//   dbg_rdata      architectural register value only, with no bypass
// ---------------------------------------------------------------------------
module lane_bypass_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int LANES = 2,
  parameter int DEPTH = 3,
  localparam int RW = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       iss_valid,
  input  logic [LANES-1:0]       iss_wen,
  input  logic [LANES-1:0]       iss_load,
  input  logic [LANES*RW-1:0]    iss_rd,
  input  logic [LANES*RW-1:0]    iss_rs_a,
  input  logic [LANES*RW-1:0]    iss_rs_b,
  output logic [LANES-1:0]       iss_accept,
  output logic [LANES*WIDTH-1:0] op_a,
  output logic [LANES*WIDTH-1:0] op_b,
  input  logic [LANES*WIDTH-1:0] ex_data,
  input  logic [LANES*WIDTH-1:0] mem_data,
  input  logic [RW-1:0]          dbg_raddr,
  output logic [WIDTH-1:0]       dbg_rdata
);

  // In-flight entries. Index 0 is S1 and index DEPTH-1 is SDEPTH.
  logic [LANES-1:0] r_valid [DEPTH];
  logic [LANES-1:0] r_wen   [DEPTH];
  logic [LANES-1:0] r_load  [DEPTH];
  logic [LANES-1:0] r_have  [DEPTH];
  logic [RW-1:0]    r_rd    [DEPTH][LANES];
  logic [WIDTH-1:0] r_data  [DEPTH][LANES];

  // Architectural register state
  logic [WIDTH-1:0] r_regs [NREGS];

  // Current result of each entry: the latched value once captured,
  // otherwise the value being delivered this cycle. An S1 entry reads
  // ex_data. A load still waiting in S2 reads mem_data.
  logic [WIDTH-1:0]       w_fwd [DEPTH][LANES];
  logic [LANES-1:0]       w_hazard;
  logic [LANES-1:0]       w_accept;
  logic [LANES*WIDTH-1:0] w_op_a;
  logic [LANES*WIDTH-1:0] w_op_b;
  logic                   w_chain;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) begin
        if (r_have[k][l]) begin
          w_fwd[k][l] = r_data[k][l];
        end else if (k == 0) begin
          w_fwd[k][l] = ex_data[l*WIDTH +: WIDTH];
        end else begin
          w_fwd[k][l] = mem_data[l*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Operand selection. The stage scan runs from oldest to youngest, so the
  // youngest matching producer is the last one assigned and therefore wins.
  // Within a stage the higher lane is younger.
  always_comb begin
    logic [RW-1:0]    w_src;
    logic             w_hz;
    logic [WIDTH-1:0] w_val;
    w_hazard = '0;
    w_op_a   = '0;
    w_op_b   = '0;
    w_src    = '0;
    w_hz     = 1'b0;
    w_val    = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int s = 0; s < 2; s++) begin
        w_src = (s == 0) ? iss_rs_a[j*RW +: RW] : iss_rs_b[j*RW +: RW];
        w_val = r_regs[w_src];
        w_hz  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          for (int l = 0; l < LANES; l++) begin
            if (r_valid[k][l] && r_wen[k][l] && (r_rd[k][l] == w_src)) begin
              // A load in S1 has no data yet, so this is the load-use stall.
              w_hz  = (k == 0) && r_load[k][l];
              w_val = w_fwd[k][l];
            end
          end
        end
        // An older lane of the same bundle writing this source cannot be
        // forwarded, because its result does not exist until it reaches S1.
        for (int i = 0; i < j; i++) begin
          if (iss_valid[i] && iss_wen[i] && (iss_rd[i*RW +: RW] == w_src)) begin
            w_hz = 1'b1;
          end
        end
        if (w_hz) begin
          w_hazard[j] = 1'b1;
        end
        if (s == 0) begin
          w_op_a[j*WIDTH +: WIDTH] = w_val;
        end else begin
          w_op_b[j*WIDTH +: WIDTH] = w_val;
        end
      end
    end
  end

  // In-order issue. Once one lane stalls, every younger lane stalls too.
  always_comb begin
    w_chain  = 1'b1;
    w_accept = '0;
    for (int j = 0; j < LANES; j++) begin
      w_chain     = w_chain & iss_valid[j] & ~w_hazard[j];
      w_accept[j] = w_chain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= '0;
        r_wen[k]   <= '0;
        r_load[k]  <= '0;
        r_have[k]  <= '0;
        for (int l = 0; l < LANES; l++) begin
          r_rd[k][l]   <= '0;
          r_data[k][l] <= '0;
        end
      end
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      // S1 is loaded from the issue ports. Lanes that were not accepted
      // enter as bubbles.
      r_valid[0] <= w_accept;
      r_wen[0]   <= iss_wen;
      r_load[0]  <= iss_load;
      r_have[0]  <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_rd[0][l]   <= iss_rd[l*RW +: RW];
        r_data[0][l] <= '0;
      end
      // Each stage advances. Results are captured on the way out of S1
      // for non-loads and on the way out of S2 for loads.
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wen[k]   <= r_wen[k-1];
        r_load[k]  <= r_load[k-1];
        for (int l = 0; l < LANES; l++) begin
          r_rd[k][l]   <= r_rd[k-1][l];
          r_data[k][l] <= w_fwd[k-1][l];
          r_have[k][l] <= r_have[k-1][l] |
                          ((k == 1) & ~r_load[k-1][l]) |
                          ((k == 2) &  r_load[k-1][l]);
        end
      end
      // Commit from SDEPTH. Lanes are visited in ascending order, so the
      // highest lane is written last and wins a same-register collision.
      for (int l = 0; l < LANES; l++) begin
        if (r_valid[DEPTH-1][l] && r_wen[DEPTH-1][l]) begin
          r_regs[r_rd[DEPTH-1][l]] <= w_fwd[DEPTH-1][l];
        end
      end
    end
  end

  assign iss_accept = w_accept;
  assign op_a       = w_op_a;
  assign op_b       = w_op_b;
  assign dbg_rdata  = r_regs[dbg_raddr];

endmodule

// File: tb/tb_lane_bypass_regfile.sv
// ---------------------------------------------------------------------------
// tb_lane_bypass_regfile
//
// Directed scenarios for reset, bypass, intra-bundle split, load-use, WAW and
// mid-flight reset, followed by randomized bundles. A reference model works
// on whole instructions, each tagged with its age in cycles since issue. It
// predicts accept, operands and the debug read for every driven cycle and
// pushes them into exp_q. A negedge monitor pops each entry and compares it
// with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_lane_bypass_regfile;
  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int LANES = 2;
  localparam int DEPTH = 3;
  localparam int RW    = 3;
  localparam int EW    = LANES + WIDTH + 2 * LANES * WIDTH;

  logic                   clk;
  logic                   rst;
  logic [LANES-1:0]       iss_valid;
  logic [LANES-1:0]       iss_wen;
  logic [LANES-1:0]       iss_load;
  logic [LANES*RW-1:0]    iss_rd;
  logic [LANES*RW-1:0]    iss_rs_a;
  logic [LANES*RW-1:0]    iss_rs_b;
  logic [LANES-1:0]       iss_accept;
  logic [LANES*WIDTH-1:0] op_a;
  logic [LANES*WIDTH-1:0] op_b;
  logic [LANES*WIDTH-1:0] ex_data;
  logic [LANES*WIDTH-1:0] mem_data;
  logic [RW-1:0]          dbg_raddr;
  logic [WIDTH-1:0]       dbg_rdata;

  lane_bypass_regfile #(
    .WIDTH(WIDTH), .NREGS(NREGS), .LANES(LANES), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_load(iss_load),
    .iss_rd(iss_rd), .iss_rs_a(iss_rs_a), .iss_rs_b(iss_rs_b),
    .iss_accept(iss_accept), .op_a(op_a), .op_b(op_b),
    .ex_data(ex_data), .mem_data(mem_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    int               age;   // 1 means S1, DEPTH means SDEPTH
    int               lane;
    bit               wen;
    bit               load;
    int               rd;
    logic [WIDTH-1:0] val;
  } rec_t;

  rec_t             fl_q[$];
  logic [WIDTH-1:0] arch [NREGS];
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    mon_e;
  int               n_cmp;
  int               n_fail;

  // Stimulus for the current cycle
  bit               st_valid [LANES];
  bit               st_wen   [LANES];
  bit               st_load  [LANES];
  int               st_rd    [LANES];
  int               st_ra    [LANES];
  int               st_rb    [LANES];
  logic [WIDTH-1:0] st_ex    [LANES];
  logic [WIDTH-1:0] st_mem   [LANES];
  int               st_dbg;
  bit               m_acc    [LANES];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Value of register r as seen by lane j, taken from the youngest
  // in-flight writer (smallest age, then higher lane).
  task automatic model_operand(input int j, input int r, output bit hz,
                               output logic [WIDTH-1:0] v);
    int best;
    best = -1;
    hz   = 1'b0;
    v    = arch[r];
    foreach (fl_q[i]) begin
      if (fl_q[i].wen && fl_q[i].rd == r) begin
        if (best < 0 || fl_q[i].age < fl_q[best].age ||
            (fl_q[i].age == fl_q[best].age && fl_q[i].lane > fl_q[best].lane))
          best = i;
      end
    end
    if (best >= 0) begin
      if (fl_q[best].age == 1 && fl_q[best].load) hz = 1'b1;
      else v = fl_q[best].val;
    end
    for (int i = 0; i < j; i++)
      if (st_valid[i] && st_wen[i] && st_rd[i] == r) hz = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle();
    bit               chain;
    bit               ha;
    bit               hb;
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [EW-1:0]    e;
    rec_t             nq[$];
    rec_t             nr;
    for (int l = 0; l < LANES; l++) begin
      iss_valid[l]                = st_valid[l];
      iss_wen[l]                  = st_wen[l];
      iss_load[l]                 = st_load[l];
      iss_rd[l*RW +: RW]          = RW'(st_rd[l]);
      iss_rs_a[l*RW +: RW]        = RW'(st_ra[l]);
      iss_rs_b[l*RW +: RW]        = RW'(st_rb[l]);
      ex_data[l*WIDTH +: WIDTH]   = st_ex[l];
      mem_data[l*WIDTH +: WIDTH]  = st_mem[l];
    end
    dbg_raddr = RW'(st_dbg);
    // Results that become known during this cycle
    foreach (fl_q[i]) begin
      if (fl_q[i].age == 1 && !fl_q[i].load) fl_q[i].val = st_ex[fl_q[i].lane];
      if (fl_q[i].age == 2 &&  fl_q[i].load) fl_q[i].val = st_mem[fl_q[i].lane];
    end
    e = '0;
    chain = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      model_operand(j, st_ra[j], ha, va);
      model_operand(j, st_rb[j], hb, vb);
      chain = chain && st_valid[j] && !ha && !hb;
      m_acc[j] = chain;
      e[j] = chain;
      e[LANES + WIDTH + j*2*WIDTH +: WIDTH]         = va;
      e[LANES + WIDTH + j*2*WIDTH + WIDTH +: WIDTH] = vb;
    end
    e[LANES +: WIDTH] = arch[st_dbg];
    exp_q.push_back(e);
    // Advance the model across the coming clock edge
    for (int l = 0; l < LANES; l++)
      foreach (fl_q[i])
        if (fl_q[i].age == DEPTH && fl_q[i].lane == l && fl_q[i].wen)
          arch[fl_q[i].rd] = fl_q[i].val;
    foreach (fl_q[i]) begin
      if (fl_q[i].age < DEPTH) begin
        nr = fl_q[i];
        nr.age++;
        nq.push_back(nr);
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (m_acc[l]) begin
        nr.age = 1; nr.lane = l; nr.wen = st_wen[l]; nr.load = st_load[l];
        nr.rd = st_rd[l]; nr.val = '0;
        nq.push_back(nr);
      end
    end
    fl_q = nq;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int l = 0; l < LANES; l++) begin
      st_valid[l] = 1'b0; st_wen[l] = 1'b0; st_load[l] = 1'b0;
      st_rd[l] = 0; st_ra[l] = 7; st_rb[l] = 7;
      st_ex[l] = WIDTH'($urandom); st_mem[l] = WIDTH'($urandom);
    end
    st_dbg = $urandom_range(0, NREGS - 1);
  endtask

  task automatic set_lane(input int l, input bit v, input bit w, input bit ld,
                          input int rd, input int ra, input int rb);
    st_valid[l] = v; st_wen[l] = w; st_load[l] = ld;
    st_rd[l] = rd; st_ra[l] = ra; st_rb[l] = rb;
  endtask

  task automatic model_reset();
    fl_q.delete();
    for (int r = 0; r < NREGS; r++) arch[r] = '0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("accept", WIDTH'(iss_accept), WIDTH'(mon_e[LANES-1:0]));
      check("dbg_rdata", dbg_rdata, mon_e[LANES +: WIDTH]);
      for (int j = 0; j < LANES; j++) begin
        if (mon_e[j]) begin
          check($sformatf("op_a lane%0d", j), op_a[j*WIDTH +: WIDTH],
                mon_e[LANES + WIDTH + j*2*WIDTH +: WIDTH]);
          check($sformatf("op_b lane%0d", j), op_b[j*WIDTH +: WIDTH],
                mon_e[LANES + WIDTH + j*2*WIDTH + WIDTH +: WIDTH]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    iss_valid = '0; iss_wen = '0; iss_load = '0;
    iss_rd = '0; iss_rs_a = '0; iss_rs_b = '0;
    ex_data = '0; mem_data = '0; dbg_raddr = '0;
    model_reset();
    set_idle();
    for (int l = 0; l < LANES; l++) m_acc[l] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("reset accept", WIDTH'(iss_accept), '0);
    check("reset op_a", op_a[WIDTH-1:0], '0);
    for (int r = 0; r < NREGS; r++) begin
      dbg_raddr = RW'(r);
      #1;
      check($sformatf("reset dbg R%0d", r), dbg_rdata, '0);
    end
    rst = 1'b0;
    tick();

    // T1: MOV R0=2, MOV R1=2
    set_idle();
    set_lane(0, 1, 1, 0, 0, 7, 7);
    set_lane(1, 1, 1, 0, 1, 7, 7);
    drive_cycle();
    check("T1 accept", WIDTH'(iss_accept), 16'h3);
    tick();
    // T2: the next bundle reads R0 and R1 through the S1 bypass
    set_idle();
    set_lane(0, 1, 0, 0, 0, 0, 0);
    set_lane(1, 1, 0, 0, 0, 1, 1);
    st_ex[0] = 16'd2; st_ex[1] = 16'd2;
    drive_cycle();
    check("T2 accept", WIDTH'(iss_accept), 16'h3);
    check("T2 op_a lane0", op_a[0 +: WIDTH], 16'd2);
    check("T2 op_b lane1", op_b[WIDTH +: WIDTH], 16'd2);
    tick();
    repeat (DEPTH + 1) begin
      set_idle(); drive_cycle(); tick();
    end
    set_idle(); st_dbg = 0; drive_cycle();
    check("T1 dbg R0", dbg_rdata, 16'd2);
    tick();
    set_idle(); st_dbg = 1; drive_cycle();
    check("T1 dbg R1", dbg_rdata, 16'd2);
    tick();

    // T3: intra-bundle dependency splits the bundle
    set_idle();
    set_lane(0, 1, 1, 0, 3, 7, 7);
    set_lane(1, 1, 0, 0, 0, 3, 7);
    drive_cycle();
    check("T3 split accept", WIDTH'(iss_accept), 16'h1);
    tick();
    set_lane(0, 1, 0, 0, 0, 7, 7);
    st_ex[0] = 16'd6;
    drive_cycle();
    check("T3 second accept", WIDTH'(iss_accept), 16'h3);
    check("T3 op_a lane1", op_a[WIDTH +: WIDTH], 16'd6);
    tick();

    // T4: load-use stall of exactly one cycle
    set_idle();
    set_lane(0, 1, 1, 1, 2, 7, 7);
    drive_cycle();
    tick();
    set_idle();
    set_lane(0, 1, 0, 0, 0, 2, 7);
    drive_cycle();
    check("T4 stall accept", WIDTH'(iss_accept), 16'h0);
    tick();
    st_mem[0] = 16'h1234;
    drive_cycle();
    check("T4 accept", WIDTH'(iss_accept), 16'h1);
    check("T4 op_a", op_a[0 +: WIDTH], 16'h1234);
    tick();

    // T5: both lanes write R5 and the higher lane wins
    set_idle();
    set_lane(0, 1, 1, 0, 5, 7, 7);
    set_lane(1, 1, 1, 0, 5, 7, 7);
    drive_cycle();
    tick();
    set_idle();
    set_lane(0, 1, 0, 0, 0, 5, 7);
    st_ex[0] = 16'h0011; st_ex[1] = 16'h0022;
    drive_cycle();
    check("T5 op_a", op_a[0 +: WIDTH], 16'h0022);
    tick();
    repeat (DEPTH + 1) begin
      set_idle(); drive_cycle(); tick();
    end
    set_idle(); st_dbg = 5; drive_cycle();
    check("T5 dbg R5", dbg_rdata, 16'h0022);
    tick();

    // T6: reset while a write to R4 sits in S2
    set_idle();
    set_lane(0, 1, 1, 0, 4, 7, 7);
    st_ex[0] = 16'hBEEF;
    drive_cycle();
    tick();
    set_idle(); st_ex[0] = 16'hBEEF; drive_cycle();
    tick();
    rst = 1'b1;
    iss_valid = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (DEPTH + 1) begin
      set_idle(); st_dbg = 4; drive_cycle(); tick();
    end
    set_idle(); st_dbg = 4; drive_cycle();
    check("T6 dbg R4", dbg_rdata, 16'h0);
    tick();

    // Randomized bundles. A lane that was not accepted is offered again
    // unchanged.
    set_idle();
    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < LANES; l++) begin
        if (!st_valid[l] || m_acc[l]) begin
          set_lane(l, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, NREGS - 1),
                   $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
        end
        st_ex[l]  = WIDTH'($urandom);
        st_mem[l] = WIDTH'($urandom);
      end
      st_dbg = $urandom_range(0, NREGS - 1);
      drive_cycle();
      tick();
    end

    set_idle();
    iss_valid = '0;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
